ram_master: RTL

//  Upstream requester for the ram block: queues load/store requests from a valid/ready

---
 rtl/ram_master_if.sv | 39 +++
 rtl/ram_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_master_if.sv
// Bundle of the client request/response channels and the ram-side
// four-phase handshake. The master modport is the ram_master view.
interface ram_master_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 64
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WORD_SIZE-1:0] resp_data;
  logic                 resp_err;
  logic                 resp_timeout;
  logic                 ram_read;
  logic                 ram_write;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [WORD_SIZE-1:0] ram_value;
  logic                 ram_txs;
  logic                 ram_txe;
  logic [WORD_SIZE-1:0] ram_out;
  logic                 ram_err;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
           ram_txe, ram_out, ram_err,
    output req_ready, resp_valid, resp_data, resp_err, resp_timeout,
           ram_read, ram_write, ram_addr, ram_value, ram_txs
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
           ram_txe, ram_out, ram_err,
    input  req_ready, resp_valid, resp_data, resp_err, resp_timeout,
           ram_read, ram_write, ram_addr, ram_value, ram_txs
  );
endinterface

// File: rtl/ram_master.sv
// Requester for the ram block: buffers client load/store requests in a small
// FIFO, runs one txs/txe four-phase handshake at a time and returns in-order
// responses. A per-phase timer aborts a handshake the ram never answers.
module ram_master #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 64,
  parameter int DEPTH     = 2,
  parameter int TIMEOUT   = 16
) (
  input logic          clk,
  input logic          rst,
  ram_master_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 fifo_write_q [DEPTH];
  logic                 fifo_write_d [DEPTH];
  logic [ADDR_SIZE-1:0] fifo_addr_q  [DEPTH];
  logic [ADDR_SIZE-1:0] fifo_addr_d  [DEPTH];
  logic [WORD_SIZE-1:0] fifo_wdata_q [DEPTH];
  logic [WORD_SIZE-1:0] fifo_wdata_d [DEPTH];
  logic                 ram_read_q, ram_read_d, ram_write_q, ram_write_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_SIZE-1:0] ram_value_q, ram_value_d;
  logic                 ram_txs_q, ram_txs_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [WORD_SIZE-1:0] resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d, resp_timeout_q, resp_timeout_d;
  logic                 req_ready_s, push_s, pop_s, expired_s;

  // Full-check uses only the occupancy, so a full FIFO never pushes and pops together.
  assign req_ready_s = (count_q < CNT_W'(DEPTH));
  assign push_s      = bus.req_valid & req_ready_s;
  // A txe still high from an aborted handshake blocks the next issue.
  assign pop_s       = (state_q == S_IDLE) & (count_q != {CNT_W{1'b0}}) & ~bus.ram_txe;
  assign expired_s   = (timer_q >= TMR_LAST);

  assign bus.req_ready    = req_ready_s;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_timeout = resp_timeout_q;
  assign bus.ram_read     = ram_read_q;
  assign bus.ram_write    = ram_write_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_value    = ram_value_q;
  assign bus.ram_txs      = ram_txs_q;

  // Next-state logic: FIFO bookkeeping, handshake sequencing and response capture.
  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    fifo_write_d   = fifo_write_q;
    fifo_addr_d    = fifo_addr_q;
    fifo_wdata_d   = fifo_wdata_q;
    ram_read_d     = ram_read_q;
    ram_write_d    = ram_write_q;
    ram_addr_d     = ram_addr_q;
    ram_value_d    = ram_value_q;
    ram_txs_d      = ram_txs_q;
    resp_valid_d   = resp_valid_q;
    resp_data_d    = resp_data_q;
    resp_err_d     = resp_err_q;
    resp_timeout_d = resp_timeout_q;
    if (timer_q == TMR_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (push_s) begin
      fifo_write_d[wr_ptr_q] = bus.req_write;
      fifo_addr_d[wr_ptr_q]  = bus.req_addr;
      fifo_wdata_d[wr_ptr_q] = bus.req_wdata;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          ram_read_d  = ~fifo_write_q[rd_ptr_q];
          ram_write_d = fifo_write_q[rd_ptr_q];
          ram_addr_d  = fifo_addr_q[rd_ptr_q];
          ram_value_d = fifo_wdata_q[rd_ptr_q];
          ram_txs_d   = 1'b1;
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
          timer_d     = {TMR_W{1'b0}};
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (bus.ram_txe) begin
          // Stores and failed accesses never return data.
          resp_data_d    = (ram_write_q | bus.ram_err) ? {WORD_SIZE{1'b0}} : bus.ram_out;
          resp_err_d     = bus.ram_err;
          resp_timeout_d = 1'b0;
        end else begin
          resp_data_d    = {WORD_SIZE{1'b0}};
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b1;
        end
        if (bus.ram_txe | expired_s) begin
          ram_read_d  = 1'b0;
          ram_write_d = 1'b0;
          ram_addr_d  = {ADDR_SIZE{1'b0}};
          ram_value_d = {WORD_SIZE{1'b0}};
          ram_txs_d   = 1'b0;
          timer_d     = {TMR_W{1'b0}};
          state_d     = S_RELEASE;
        end else begin
          resp_data_d    = resp_data_q;
          resp_err_d     = resp_err_q;
          resp_timeout_d = resp_timeout_q;
        end
      end
      S_RELEASE: begin
        if (~bus.ram_txe) begin
          resp_valid_d = 1'b1;
          timer_d      = {TMR_W{1'b0}};
          state_d      = S_RESP;
        end else if (expired_s) begin
          // Ram presumed dead: report a timeout and let IDLE wait out the stale txe.
          resp_valid_d   = 1'b1;
          resp_data_d    = {WORD_SIZE{1'b0}};
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b1;
          timer_d        = {TMR_W{1'b0}};
          state_d        = S_RESP;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d   = 1'b0;
          resp_data_d    = {WORD_SIZE{1'b0}};
          resp_err_d     = 1'b0;
          resp_timeout_d = 1'b0;
          timer_d        = {TMR_W{1'b0}};
          state_d        = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops txs at once and discards queued work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      timer_q        <= {TMR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      wr_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_write_q[i] <= 1'b0;
        fifo_addr_q[i]  <= {ADDR_SIZE{1'b0}};
        fifo_wdata_q[i] <= {WORD_SIZE{1'b0}};
      end
      ram_read_q     <= 1'b0;
      ram_write_q    <= 1'b0;
      ram_addr_q     <= {ADDR_SIZE{1'b0}};
      ram_value_q    <= {WORD_SIZE{1'b0}};
      ram_txs_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= {WORD_SIZE{1'b0}};
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      fifo_write_q   <= fifo_write_d;
      fifo_addr_q    <= fifo_addr_d;
      fifo_wdata_q   <= fifo_wdata_d;
      ram_read_q     <= ram_read_d;
      ram_write_q    <= ram_write_d;
      ram_addr_q     <= ram_addr_d;
      ram_value_q    <= ram_value_d;
      ram_txs_q      <= ram_txs_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end
endmodule
